ifid_queue: RTL and testbench

- Parametrised IF/ID stage register for the pipelined MIPS CPU.
- Replaces the single IF/ID latch with a DEPTH-entry queue of {pc, instruction} pairs, fed by fetch through a valid/ready handshake.
- Drives a registered instruction slot to ID, with stall hold and flush-to-bubble on a taken jump.
- Decode logic (mainControl/aluControl) stays downstream and consumes id_ins/id_pc unchanged.

---
 rtl/ifid_pkg.sv | 23 ++
 rtl/ifid_ring.sv | 54 +++++
 rtl/ifid_queue.sv | 133 +++++++++++++
 tb/tb_ifid_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID queue.
// The IFID_QUEUE_PERF_EN build adds stall/bubble counters.
package ifid_pkg;

    localparam int          IFID_XLEN  = 32;
    localparam logic [31:0] BUBBLE_INS = 32'hFC00_0000;
    // Used downstream to force the destination register for jal.
    localparam logic [5:0]  OP_JAL     = 6'b000011;

    typedef struct packed {
        logic [IFID_XLEN-1:0] pc;
        logic [IFID_XLEN-1:0] ins;
    } fetch_pkt_t;

    // Decides what the ID slot loads on the next falling edge.
    typedef enum logic [1:0] {
        SLOT_FLUSH  = 2'd0,
        SLOT_HOLD   = 2'd1,
        SLOT_POP    = 2'd2,
        SLOT_BUBBLE = 2'd3
    } slot_sel_t;

endpackage

// File: rtl/ifid_ring.sv
// DEPTH-entry ring buffer holding packed {pc, ins} pairs for the IF/ID queue.
// It updates on the falling clock edge, like the rest of the pipeline.
module ifid_ring #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage write; contents are deliberately left unreset.
    always_ff @(negedge clk) begin
        if (push) begin
            mem_r[wptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties without moving wptr.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            rptr_r  <= wptr_r;
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wptr_r <= wptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rptr_r <= rptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_r <= count_r + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    assign head  = mem_r[rptr_r];
    assign count = count_r;

endmodule

// File: rtl/ifid_queue.sv
// IF/ID stage: a fetch queue feeding a registered ID slot with stall hold and flush-to-bubble.
// Optional IFID_QUEUE_PERF_EN adds stall_cnt/bubble_cnt outputs.
module ifid_queue
    import ifid_pkg::*;
#(
    parameter  int              XLEN       = ifid_pkg::IFID_XLEN,
    parameter  int              DEPTH      = 4,
    parameter  logic [XLEN-1:0] BUBBLE_INS = XLEN'(ifid_pkg::BUBBLE_INS),
    localparam int              CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [XLEN-1:0]  if_ins,
    output logic             if_ready,
    input  logic             flush,
    input  logic             stall,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_ins,
    output logic [CNT_W-1:0] count
`ifdef IFID_QUEUE_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
`endif
);

    logic            push_s;
    logic            pop_s;
    logic [2*XLEN-1:0] wr_data_s;
    logic [2*XLEN-1:0] head_s;
    slot_sel_t       slot_sel_s;
    logic            id_valid_r;
    logic [XLEN-1:0] id_pc_r;
    logic [XLEN-1:0] id_ins_r;

    // Full blocks fetch even when a pop frees a slot on the same edge.
    assign if_ready  = (count < CNT_W'(DEPTH));
    assign wr_data_s = {if_pc, if_ins};

    ifid_ring #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .clear   (flush),
        .wr_data (wr_data_s),
        .head    (head_s),
        .count   (count)
    );

    // Handshake qualification and ID slot priority: flush > stall > pop > bubble.
    always_comb begin
        push_s     = if_valid && if_ready && !flush;
        pop_s      = 1'b0;
        slot_sel_s = SLOT_BUBBLE;
        if (flush) begin
            slot_sel_s = SLOT_FLUSH;
        end else if (stall) begin
            slot_sel_s = SLOT_HOLD;
        end else if (count != {CNT_W{1'b0}}) begin
            slot_sel_s = SLOT_POP;
            pop_s      = 1'b1;
        end else begin
            slot_sel_s = SLOT_BUBBLE;
        end
    end

    // ID slot register presented to decode.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_r <= 1'b0;
            id_pc_r    <= {XLEN{1'b0}};
            id_ins_r   <= BUBBLE_INS;
        end else begin
            case (slot_sel_s)
                SLOT_HOLD: begin
                    id_valid_r <= id_valid_r;
                    id_pc_r    <= id_pc_r;
                    id_ins_r   <= id_ins_r;
                end
                SLOT_POP: begin
                    id_valid_r <= 1'b1;
                    id_pc_r    <= head_s[2*XLEN-1:XLEN];
                    id_ins_r   <= head_s[XLEN-1:0];
                end
                SLOT_FLUSH, SLOT_BUBBLE: begin
                    id_valid_r <= 1'b0;
                    id_pc_r    <= {XLEN{1'b0}};
                    id_ins_r   <= BUBBLE_INS;
                end
                default: begin
                    id_valid_r <= 1'b0;
                    id_pc_r    <= {XLEN{1'b0}};
                    id_ins_r   <= BUBBLE_INS;
                end
            endcase
        end
    end

    assign id_valid = id_valid_r;
    assign id_pc    = id_pc_r;
    assign id_ins   = id_ins_r;

`ifdef IFID_QUEUE_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] bubble_cnt_r;

    // Hazard statistics; both counters wrap naturally at 2^32.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else begin
            if (slot_sel_s == SLOT_HOLD) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if ((slot_sel_s == SLOT_FLUSH) || (slot_sel_s == SLOT_BUBBLE)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_ifid_queue.sv
// Directed self-checking bench for ifid_queue (DEPTH=4); state changes on negedge, checks on posedge.
// Define IFID_QUEUE_PERF_EN to also cover the stall/bubble counters.
module tb_ifid_queue;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        if_ready;
    logic        flush;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_ins;
    logic [2:0]  count;
`ifdef IFID_QUEUE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    int n_assert;
    int n_fail;

    localparam logic [31:0] BUB = 32'hFC00_0000;

    ifid_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_ins   (if_ins),
        .if_ready (if_ready),
        .flush    (flush),
        .stall    (stall),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_ins   (id_ins),
        .count    (count)
`ifdef IFID_QUEUE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One falling (active) edge, then return at the following rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        if_valid = v;
        if_pc    = pc;
        if_ins   = ins;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        drive(1'b0, 32'd0, 32'd0);

        tick();
        tick();
        chk("rst_id_ins", id_ins, BUB);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
        rst_n = 1'b1;

`ifdef IFID_QUEUE_PERF_EN
        stall = 1'b1;
        tick(); tick(); tick();
        stall = 1'b0;
        chk("perf_stall3", stall_cnt, 32'd3);
        chk("perf_bub0", bubble_cnt, 32'd0);
        tick(); tick();
        chk("perf_bub2", bubble_cnt, 32'd2);
        chk("perf_stall_keep", stall_cnt, 32'd3);
        stall = 1'b1;
        drive(1'b1, 32'h0000_0ABC, 32'h1234_5678);
        tick();
        rst_n = 1'b0;
        #1;
        chk("perf_rst_stall", stall_cnt, 32'd0);
        chk("perf_rst_bub", bubble_cnt, 32'd0);
        stall = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        rst_n = 1'b1;
`endif

        // Streaming: each instruction reaches ID one edge after its push.
        drive(1'b1, 32'd4, 32'h2001_0001);
        tick();
        chk("st_cnt1", {29'd0, count}, 32'd1);
        chk("st_nobypass", {31'd0, id_valid}, 32'd0);
        drive(1'b1, 32'd8, 32'h2001_0002);
        tick();
        chk("st_ins1", id_ins, 32'h2001_0001);
        chk("st_pc1", id_pc, 32'd4);
        chk("st_val1", {31'd0, id_valid}, 32'd1);
        chk("st_cnt_pp", {29'd0, count}, 32'd1);
        drive(1'b1, 32'd12, 32'h2001_0003);
        tick();
        chk("st_ins2", id_ins, 32'h2001_0002);
        chk("st_pc2", id_pc, 32'd8);
        drive(1'b1, 32'd16, 32'h2001_0004);
        tick();
        chk("st_ins3", id_ins, 32'h2001_0003);
        drive(1'b0, 32'd0, 32'd0);
        tick();
        chk("st_ins4", id_ins, 32'h2001_0004);
        chk("st_pc4", id_pc, 32'd16);
        chk("st_cnt0", {29'd0, count}, 32'd0);
        tick();
        chk("st_bubble", id_ins, BUB);
        chk("st_bub_val", {31'd0, id_valid}, 32'd0);

        // Fill under stall: the fifth push must be refused.
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 32'h3000_0001 + 32'(k));
            tick();
            if (k == 3) begin
                chk("fill_cnt4", {29'd0, count}, 32'd4);
                chk("fill_notready", {31'd0, if_ready}, 32'd0);
                chk("fill_hold_bub", {31'd0, id_valid}, 32'd0);
            end
        end
        chk("fill_cnt_5th", {29'd0, count}, 32'd4);
        stall = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        chk("drain_ins1", id_ins, 32'h3000_0001);
        chk("drain_pc1", id_pc, 32'h100);
        chk("drain_cnt3", {29'd0, count}, 32'd3);
        chk("drain_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("drain_ins2", id_ins, 32'h3000_0002);
        tick();
        chk("drain_ins3", id_ins, 32'h3000_0003);
        tick();
        chk("drain_ins4", id_ins, 32'h3000_0004);
        chk("drain_pc4", id_pc, 32'h10C);
        chk("drain_cnt0", {29'd0, count}, 32'd0);
        tick();
        chk("drain_bubble", id_ins, BUB);
        chk("drain_bub_val", {31'd0, id_valid}, 32'd0);

        // Stall while empty keeps a valid instruction in the slot.
        drive(1'b1, 32'h200, 32'h4000_0001);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        tick();
        chk("hold_load", id_ins, 32'h4000_0001);
        stall = 1'b1;
        tick();
        chk("hold_ins", id_ins, 32'h4000_0001);
        chk("hold_pc", id_pc, 32'h200);
        chk("hold_val", {31'd0, id_valid}, 32'd1);

        // Fill to full under stall, then flush+stall with a push attempt.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h300 + 32'(4 * k), 32'h5000_0001 + 32'(k));
            tick();
        end
        chk("fl_full", {29'd0, count}, 32'd4);
        flush = 1'b1;
        drive(1'b1, 32'h310, 32'h5000_00FF);
        tick();
        chk("fl_ins", id_ins, BUB);
        chk("fl_pc", id_pc, 32'd0);
        chk("fl_val", {31'd0, id_valid}, 32'd0);
        chk("fl_cnt", {29'd0, count}, 32'd0);
        chk("fl_ready", {31'd0, if_ready}, 32'd1);
        stall = 1'b0;
        drive(1'b1, 32'h314, 32'h5000_00EE);
        tick();
        chk("fl_push_drop", {29'd0, count}, 32'd0);
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        chk("fl_after_ins", id_ins, BUB);
        chk("fl_after_val", {31'd0, id_valid}, 32'd0);

        // Asynchronous reset in the middle of streaming.
        drive(1'b1, 32'h400, 32'h6000_0001);
        tick();
        drive(1'b1, 32'h404, 32'h6000_0002);
        tick();
        chk("mr_pre_ins", id_ins, 32'h6000_0001);
        chk("mr_pre_cnt", {29'd0, count}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_cnt", {29'd0, count}, 32'd0);
        chk("mr_val", {31'd0, id_valid}, 32'd0);
        chk("mr_ins", id_ins, BUB);
        chk("mr_pc", id_pc, 32'd0);
        drive(1'b0, 32'd0, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_after_val", {31'd0, id_valid}, 32'd0);
        chk("mr_after_cnt", {29'd0, count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
